// File: rtl/router_hdr_rewrite.sv
// Router header rewrite stage: captures the first beat of each packet, asks the
// ARP/LPM lookup for a next hop, rewrites MACs/TTL/checksum or punts to the CPU.
module router_hdr_rewrite #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                                AXI_ACLK,
  input  logic                                AXI_RESET,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic                                S_AXIS_TVALID,
  input  logic                                S_AXIS_TLAST,
  output logic                                S_AXIS_TREADY,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                                M_AXIS_TVALID,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,

  output logic                                lkup_req,
  input  logic                                lkup_valid,
  input  logic                                lkup_hit,
  input  logic [47:0]                         lkup_dst_mac,
  input  logic [7:0]                          lkup_oq,

  input  logic [47:0]                         src_mac0,
  input  logic [47:0]                         src_mac1,
  input  logic [47:0]                         src_mac2,
  input  logic [47:0]                         src_mac3,

  output logic [31:0]                         fwd_count,
  output logic [31:0]                         miss_count,
  output logic [31:0]                         ttl_exp_count
);

  typedef enum logic [1:0] {IDLE, WAIT, HEAD, BODY} state_t;
  typedef enum logic [1:0] {KIND_BYPASS, KIND_FWD, KIND_MISS, KIND_TTL} kind_t;

  state_t                               state;
  kind_t                                kind;
  logic [C_S_AXIS_DATA_WIDTH-1:0]       hdr_data;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     hdr_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]      hdr_user;
  logic                                 hdr_last;

  logic [7:0]  src_byte;
  logic [7:0]  cpu_dst_byte;
  logic [3:0]  mac_bits;
  logic        oq_valid;
  logic [47:0] sel_src_mac;
  logic        ttl_ok;
  logic [16:0] csum_sum;
  logic [15:0] csum_new;

  // Lookup decode: exactly one MAC-port bit of lkup_oq must be set for a forward
  always_comb begin
    src_byte     = hdr_user[SRC_PORT_POS +: 8];
    cpu_dst_byte = {src_byte[6:0], 1'b0};
    mac_bits     = {lkup_oq[6], lkup_oq[4], lkup_oq[2], lkup_oq[0]};
    oq_valid     = 1'b0;
    sel_src_mac  = src_mac0;
    case (mac_bits)
      4'b0001: begin oq_valid = 1'b1; sel_src_mac = src_mac0; end
      4'b0010: begin oq_valid = 1'b1; sel_src_mac = src_mac1; end
      4'b0100: begin oq_valid = 1'b1; sel_src_mac = src_mac2; end
      4'b1000: begin oq_valid = 1'b1; sel_src_mac = src_mac3; end
      default: begin oq_valid = 1'b0; sel_src_mac = src_mac0; end
    endcase
    ttl_ok   = hdr_data[79:72] > 8'd1;
    // TTL sits in the high byte of its checksum word, so decrementing it adds 0x0100
    csum_sum = {1'b0, hdr_data[63:48]} + 17'h00100;
    csum_new = csum_sum[15:0] + {15'd0, csum_sum[16]};
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state         <= IDLE;
      kind          <= KIND_BYPASS;
      hdr_data      <= '0;
      hdr_strb      <= '0;
      hdr_user      <= '0;
      hdr_last      <= 1'b0;
      lkup_req      <= 1'b0;
      fwd_count     <= '0;
      miss_count    <= '0;
      ttl_exp_count <= '0;
    end else begin
      lkup_req <= 1'b0;
      case (state)
        IDLE: begin
          if (S_AXIS_TVALID) begin
            hdr_data <= S_AXIS_TDATA;
            hdr_strb <= S_AXIS_TSTRB;
            hdr_user <= S_AXIS_TUSER;
            hdr_last <= S_AXIS_TLAST;
            if (S_AXIS_TUSER[DST_PORT_POS +: 8] != 8'd0) begin
              kind  <= KIND_BYPASS;
              state <= HEAD;
            end else begin
              lkup_req <= 1'b1;
              state    <= WAIT;
            end
          end
        end

        WAIT: begin
          if (lkup_valid) begin
            if (lkup_hit && oq_valid && ttl_ok) begin
              hdr_data[255:208]              <= lkup_dst_mac;
              hdr_data[207:160]              <= sel_src_mac;
              hdr_data[79:72]                <= hdr_data[79:72] - 8'd1;
              hdr_data[63:48]                <= csum_new;
              hdr_user[DST_PORT_POS +: 8]    <= lkup_oq;
              kind                           <= KIND_FWD;
            end else if (lkup_hit && oq_valid) begin
              hdr_user[DST_PORT_POS +: 8]    <= cpu_dst_byte;
              kind                           <= KIND_TTL;
            end else begin
              hdr_user[DST_PORT_POS +: 8]    <= cpu_dst_byte;
              kind                           <= KIND_MISS;
            end
            state <= HEAD;
          end
        end

        HEAD: begin
          if (M_AXIS_TREADY) begin
            case (kind)
              KIND_FWD:  fwd_count     <= fwd_count + 32'd1;
              KIND_MISS: miss_count    <= miss_count + 32'd1;
              KIND_TTL:  ttl_exp_count <= ttl_exp_count + 32'd1;
              default:   ;
            endcase
            state <= hdr_last ? IDLE : BODY;
          end
        end

        BODY: begin
          if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Stream muxing: registered header in HEAD, straight wire-through in BODY
  always_comb begin
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = hdr_data;
    M_AXIS_TSTRB  = hdr_strb;
    M_AXIS_TUSER  = hdr_user;
    M_AXIS_TLAST  = hdr_last;
    if (!AXI_RESET) begin
      case (state)
        IDLE: S_AXIS_TREADY = 1'b1;
        HEAD: M_AXIS_TVALID = 1'b1;
        BODY: begin
          M_AXIS_TVALID = S_AXIS_TVALID;
          M_AXIS_TDATA  = S_AXIS_TDATA;
          M_AXIS_TSTRB  = S_AXIS_TSTRB;
          M_AXIS_TUSER  = S_AXIS_TUSER;
          M_AXIS_TLAST  = S_AXIS_TLAST;
          S_AXIS_TREADY = M_AXIS_TREADY;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_hdr_rewrite.sv
// Directed self-checking bench for router_hdr_rewrite: forward, checksum carry,
// miss, TTL expiry, CPU bypass, ready toggling and mid-packet reset.
module tb_router_hdr_rewrite;

  logic         AXI_ACLK = 1'b0;
  logic         AXI_RESET;
  logic [255:0] S_AXIS_TDATA;
  logic [31:0]  S_AXIS_TSTRB;
  logic [127:0] S_AXIS_TUSER;
  logic         S_AXIS_TVALID;
  logic         S_AXIS_TLAST;
  logic         S_AXIS_TREADY;
  logic [255:0] M_AXIS_TDATA;
  logic [31:0]  M_AXIS_TSTRB;
  logic [127:0] M_AXIS_TUSER;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TLAST;
  logic         M_AXIS_TREADY;
  logic         lkup_req;
  logic         lkup_valid;
  logic         lkup_hit;
  logic [47:0]  lkup_dst_mac;
  logic [7:0]   lkup_oq;
  logic [47:0]  src_mac0, src_mac1, src_mac2, src_mac3;
  logic [31:0]  fwd_count, miss_count, ttl_exp_count;

  int errors = 0;
  int checks = 0;

  localparam logic [47:0] SRC_MAC0 = 48'h02_53_55_4D_45_00;
  localparam logic [47:0] SRC_MAC1 = 48'h02_53_55_4D_45_11;
  localparam logic [47:0] SRC_MAC2 = 48'h02_53_55_4D_45_22;
  localparam logic [47:0] SRC_MAC3 = 48'h02_53_55_4D_45_33;
  localparam logic [47:0] NH_MAC   = 48'h00_1B_21_AA_BB_CC;

  always #5 AXI_ACLK = ~AXI_ACLK;

  router_hdr_rewrite dut (
    .AXI_ACLK      (AXI_ACLK),
    .AXI_RESET     (AXI_RESET),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TSTRB  (S_AXIS_TSTRB),
    .S_AXIS_TUSER  (S_AXIS_TUSER),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TSTRB  (M_AXIS_TSTRB),
    .M_AXIS_TUSER  (M_AXIS_TUSER),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .lkup_req      (lkup_req),
    .lkup_valid    (lkup_valid),
    .lkup_hit      (lkup_hit),
    .lkup_dst_mac  (lkup_dst_mac),
    .lkup_oq       (lkup_oq),
    .src_mac0      (src_mac0),
    .src_mac1      (src_mac1),
    .src_mac2      (src_mac2),
    .src_mac3      (src_mac3),
    .fwd_count     (fwd_count),
    .miss_count    (miss_count),
    .ttl_exp_count (ttl_exp_count)
  );

  task automatic check_output(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] mk_hdr(input logic [7:0] ttl, input logic [15:0] csum);
    logic [255:0] r;
    r = {8{32'h4500_0054}};
    r[255:208] = 48'hFFFF_FFFF_FFFF;
    r[207:160] = 48'h0A0B_0C0D_0E0F;
    r[79:72]   = ttl;
    r[63:48]   = csum;
    return r;
  endfunction

  function automatic logic [255:0] fwd_hdr(input logic [255:0] base, input logic [47:0] smac,
                                           input logic [7:0] ttl, input logic [15:0] csum);
    logic [255:0] r;
    r = base;
    r[255:208] = NH_MAC;
    r[207:160] = smac;
    r[79:72]   = ttl;
    r[63:48]   = csum;
    return r;
  endfunction

  function automatic logic [127:0] mk_user(input logic [7:0] src, input logic [7:0] dst);
    return {96'hDEAD_BEEF_0123_4567_89AB_CDEF, dst, src, 16'hCAFE};
  endfunction

  // Drives one whole packet through the DUT and checks header, lookup handshake and body beats
  task automatic apply_stimulus(input string tag, input logic [255:0] d0, input logic [127:0] u0,
                                input int nbeats, input bit do_lookup, input int wait_cycles,
                                input bit hit, input logic [7:0] oq, input bit toggle,
                                input logic [255:0] exp_data, input logic [7:0] exp_dst);
    logic [127:0] exp_user;
    logic [255:0] bd;
    int i, cyc, out_beats;
    exp_user = u0;
    exp_user[31:24] = exp_dst;

    @(negedge AXI_ACLK);
    S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = d0; S_AXIS_TUSER = u0;
    S_AXIS_TSTRB = '1; S_AXIS_TLAST = (nbeats == 1);
    @(posedge AXI_ACLK);
    @(negedge AXI_ACLK);
    S_AXIS_TVALID = 1'b0;
    #1;
    check_output({tag, "_lkup_req"}, lkup_req, do_lookup);
    if (do_lookup) begin
      for (int w = 0; w < wait_cycles; w++) begin
        check_output({tag, "_wait_tready"}, S_AXIS_TREADY, 1'b0);
        check_output({tag, "_wait_tvalid"}, M_AXIS_TVALID, 1'b0);
        @(negedge AXI_ACLK);
      end
      lkup_valid = 1'b1; lkup_hit = hit; lkup_dst_mac = NH_MAC; lkup_oq = oq;
      @(negedge AXI_ACLK);
      lkup_valid = 1'b0; lkup_hit = 1'b0; lkup_oq = 8'h00;
      #1;
      check_output({tag, "_req_pulse"}, lkup_req, 1'b0);
    end
    check_output({tag, "_head_valid"}, M_AXIS_TVALID, 1'b1);
    check_output({tag, "_head_tready"}, S_AXIS_TREADY, 1'b0);
    check_output({tag, "_head_data"}, M_AXIS_TDATA, exp_data);
    check_output({tag, "_head_user"}, M_AXIS_TUSER, exp_user);
    check_output({tag, "_head_last"}, M_AXIS_TLAST, nbeats == 1);
    M_AXIS_TREADY = 1'b1;
    @(posedge AXI_ACLK);
    out_beats = 1;

    i = 1; cyc = 0;
    while (i < nbeats && cyc < 64) begin
      @(negedge AXI_ACLK);
      bd = {8{32'hB0D0_0000 + i[31:0]}};
      S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = bd; S_AXIS_TLAST = (i == nbeats - 1);
      M_AXIS_TREADY = toggle ? cyc[0] : 1'b1;
      #1;
      check_output({tag, "_body_valid"}, M_AXIS_TVALID, 1'b1);
      check_output({tag, "_body_data"}, M_AXIS_TDATA, bd);
      check_output({tag, "_body_ready"}, S_AXIS_TREADY, M_AXIS_TREADY);
      if (M_AXIS_TVALID && M_AXIS_TREADY) out_beats++;
      @(posedge AXI_ACLK);
      if (M_AXIS_TREADY) i++;
      cyc++;
    end
    check_output({tag, "_body_done"}, i, nbeats);

    @(negedge AXI_ACLK);
    S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; M_AXIS_TREADY = 1'b0;
    #1;
    check_output({tag, "_beats"}, out_beats, nbeats);
    check_output({tag, "_idle_tready"}, S_AXIS_TREADY, 1'b1);
    check_output({tag, "_idle_tvalid"}, M_AXIS_TVALID, 1'b0);
  endtask

  logic [255:0] base;
  logic [255:0] bd0;

  initial begin
    AXI_RESET = 1'b1;
    S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0; S_AXIS_TUSER = '0;
    S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; M_AXIS_TREADY = 1'b0;
    lkup_valid = 1'b0; lkup_hit = 1'b0; lkup_dst_mac = '0; lkup_oq = '0;
    src_mac0 = SRC_MAC0; src_mac1 = SRC_MAC1; src_mac2 = SRC_MAC2; src_mac3 = SRC_MAC3;

    // Reset state
    repeat (3) @(posedge AXI_ACLK);
    @(negedge AXI_ACLK);
    check_output("rst_tready", S_AXIS_TREADY, 1'b0);
    check_output("rst_tvalid", M_AXIS_TVALID, 1'b0);
    check_output("rst_lkup_req", lkup_req, 1'b0);
    check_output("rst_fwd", fwd_count, 32'd0);
    check_output("rst_miss", miss_count, 32'd0);
    check_output("rst_ttl", ttl_exp_count, 32'd0);
    AXI_RESET = 1'b0;
    #1;
    check_output("post_rst_tready", S_AXIS_TREADY, 1'b1);

    $display("[TB] hit forward, 3 beats");
    base = mk_hdr(8'h40, 16'hB1E6);
    apply_stimulus("hit", base, mk_user(8'h01, 8'h00), 3, 1, 0, 1, 8'h04, 0,
                   fwd_hdr(base, SRC_MAC1, 8'h3F, 16'hB2E6), 8'h04);
    check_output("hit_fwd_count", fwd_count, 32'd1);
    check_output("hit_miss_count", miss_count, 32'd0);

    $display("[TB] checksum end-around carry, 1 beat");
    base = mk_hdr(8'h40, 16'hFF80);
    apply_stimulus("carry", base, mk_user(8'h04, 8'h00), 1, 1, 0, 1, 8'h40, 0,
                   fwd_hdr(base, SRC_MAC3, 8'h3F, 16'h0081), 8'h40);
    check_output("carry_fwd_count", fwd_count, 32'd2);

    $display("[TB] miss from port 2");
    base = mk_hdr(8'h40, 16'h1234);
    apply_stimulus("miss", base, mk_user(8'h10, 8'h00), 2, 1, 3, 0, 8'h04, 0, base, 8'h20);
    check_output("miss_count", miss_count, 32'd1);
    check_output("miss_fwd_count", fwd_count, 32'd2);

    $display("[TB] TTL expired");
    base = mk_hdr(8'h01, 16'h5555);
    apply_stimulus("ttl", base, mk_user(8'h10, 8'h00), 2, 1, 0, 1, 8'h04, 0, base, 8'h20);
    check_output("ttl_exp_count", ttl_exp_count, 32'd1);
    check_output("ttl_fwd_count", fwd_count, 32'd2);

    $display("[TB] hit with two MAC-port bits");
    base = mk_hdr(8'h40, 16'h7777);
    apply_stimulus("badoq", base, mk_user(8'h01, 8'h00), 1, 1, 0, 1, 8'h05, 0, base, 8'h02);
    check_output("badoq_miss_count", miss_count, 32'd2);

    $display("[TB] CPU bypass packet");
    base = {4{64'h0123_4567_89AB_CDEF}};
    apply_stimulus("cpu", base, mk_user(8'h02, 8'h01), 2, 0, 0, 0, 8'h00, 0, base, 8'h01);
    check_output("cpu_fwd_count", fwd_count, 32'd2);
    check_output("cpu_miss_count", miss_count, 32'd2);
    check_output("cpu_ttl_count", ttl_exp_count, 32'd1);

    $display("[TB] ready toggling in BODY, TTL 2 forwards");
    base = mk_hdr(8'h02, 16'h0000);
    apply_stimulus("toggle", base, mk_user(8'h02, 8'h00), 4, 1, 0, 1, 8'h01, 1,
                   fwd_hdr(base, SRC_MAC0, 8'h01, 16'h0100), 8'h01);
    check_output("toggle_fwd_count", fwd_count, 32'd3);

    $display("[TB] reset during BODY");
    @(negedge AXI_ACLK);
    S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = mk_hdr(8'h40, 16'h1111);
    S_AXIS_TUSER = mk_user(8'h01, 8'h00); S_AXIS_TLAST = 1'b0;
    @(negedge AXI_ACLK);
    S_AXIS_TVALID = 1'b0;
    lkup_valid = 1'b1; lkup_hit = 1'b0;
    @(negedge AXI_ACLK);
    lkup_valid = 1'b0;
    M_AXIS_TREADY = 1'b1;
    @(negedge AXI_ACLK);
    bd0 = {8{32'h5A5A_0001}};
    S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = bd0;
    #1;
    check_output("mid_body_data", M_AXIS_TDATA, bd0);
    check_output("mid_miss_count", miss_count, 32'd3);
    AXI_RESET = 1'b1;
    #1;
    check_output("mid_rst_tvalid", M_AXIS_TVALID, 1'b0);
    check_output("mid_rst_tready", S_AXIS_TREADY, 1'b0);
    @(negedge AXI_ACLK);
    check_output("mid_rst_lkup_req", lkup_req, 1'b0);
    check_output("mid_rst_fwd", fwd_count, 32'd0);
    check_output("mid_rst_miss", miss_count, 32'd0);
    check_output("mid_rst_ttl", ttl_exp_count, 32'd0);
    check_output("mid_rst_tvalid2", M_AXIS_TVALID, 1'b0);
    S_AXIS_TVALID = 1'b0; M_AXIS_TREADY = 1'b0;
    AXI_RESET = 1'b0;

    base = mk_hdr(8'h80, 16'hABCD);
    apply_stimulus("after_rst", base, mk_user(8'h40, 8'h00), 2, 1, 0, 1, 8'h10, 0,
                   fwd_hdr(base, SRC_MAC2, 8'h7F, 16'hACCD), 8'h10);
    check_output("after_rst_fwd", fwd_count, 32'd1);
    check_output("after_rst_miss", miss_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_hdr_rewrite.md
ROUTER_HDR_REWRITE -- requirements
Module: router_hdr_rewrite

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, input stream data width.
REQ-002 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256, output stream data width.
REQ-003 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, TUSER width on both streams.
REQ-004 SHALL have parameter SRC_PORT_POS, default 16, LSB of the one-hot source-port byte in TUSER.
REQ-005 SHALL have parameter DST_PORT_POS, default 24, LSB of the one-hot destination-port byte in TUSER.
REQ-006 SHALL have port AXI_ACLK, in, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port AXI_RESET, in, 1, synchronous reset, active-high.
REQ-008 SHALL have S_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST, in, 256/32/128/1/1, packet stream from the ARP stage.
REQ-009 SHALL have S_AXIS_TREADY, out, 1, input backpressure.
REQ-010 SHALL have M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST, out, 256/32/128/1/1, stream to the output queues.
REQ-011 SHALL have M_AXIS_TREADY, in, 1, output backpressure.
REQ-012 SHALL have lkup_req, out, 1, one-cycle pulse when a routable header is captured.
REQ-013 SHALL have lkup_valid, in, 1, lookup result strobe; sampled only in WAIT.
REQ-014 SHALL have lkup_hit, in, 1, 1 = ARP/LPM hit.
REQ-015 SHALL have lkup_dst_mac, in, 48, next-hop MAC.
REQ-016 SHALL have lkup_oq, in, 8, one-hot output port (bits 0/2/4/6 = MAC ports 0-3).
REQ-017 SHALL have src_mac0..src_mac3, in, 48 each, router MAC of ports 0-3.
REQ-018 SHALL have fwd_count, out, 32, packets forwarded with rewrite.
REQ-019 SHALL have miss_count, out, 32, packets punted to CPU on lookup miss.
REQ-020 SHALL have ttl_exp_count, out, 32, packets punted for TTL <= 1.

Function
REQ-021 SHALL implement states IDLE, WAIT, HEAD, BODY.
REQ-022 IDLE: S_AXIS_TREADY=1, M_AXIS_TVALID=0; on S_AXIS_TVALID, register first beat (data, strb, user, last); if TUSER dst byte != 0 (CPU-sent) go HEAD with bypass flag set, else pulse lkup_req next cycle and go WAIT.
REQ-023 WAIT: S_AXIS_TREADY=0; on lkup_valid, latch hit/dst_mac/oq, go HEAD; waits indefinitely otherwise.
REQ-024 HEAD: M_AXIS_TVALID=1 with modified first beat, S_AXIS_TREADY=0; on M_AXIS_TREADY go BODY, or IDLE if registered TLAST=1.
REQ-025 BODY: combinational pass-through (M_AXIS_* = S_AXIS_*, S_AXIS_TREADY = M_AXIS_TREADY); beat accepted with TLAST returns to IDLE.
REQ-026 Hit and TTL (TDATA[79:72]) > 1: TDATA[255:208]=lkup_dst_mac, [207:160]=src_macN for the set lkup_oq bit, TTL-1, checksum [63:48] = old + 16'h0100 with end-around carry, TUSER dst byte = lkup_oq; fwd_count+1.
REQ-027 Hit and TTL <= 1: data unchanged, dst byte = source one-hot shifted left 1 (CPU port); ttl_exp_count+1.
REQ-028 Miss: data unchanged, dst byte = source one-hot shifted left 1; miss_count+1.
REQ-029 Bypass: first beat forwarded unmodified, no lookup, no counter change.
REQ-030 Counters SHALL wrap modulo 2^32; each increments once per packet, on HEAD handshake.
REQ-031 Minimum latency: header out 2 cycles after capture when lkup_valid arrives in first WAIT cycle; one header beat in flight at a time.
REQ-032 lkup_oq with zero or multiple MAC-port bits on hit SHALL be treated as miss.

Reset
REQ-033 On AXI_RESET (even mid-packet): state IDLE, M_AXIS_TVALID=0, lkup_req=0, S_AXIS_TREADY=0 during reset, all counters 0, registered beat cleared.
REQ-034 After reset deassertion, first input beat SHALL be treated as a packet start.

Verification
REQ-035 Hit: 3-beat IPv4 pkt, TTL 0x40, csum 0xB1E6, src port0, lkup_oq=0x04 -> TTL 0x3F, csum 0xB2E6, src MAC=src_mac1, dst byte 0x04, fwd_count=1.
REQ-036 Checksum carry: csum 0xFF80, hit -> 0x0081.
REQ-037 Miss from port 2 (src 0x10) -> dst 0x20, data identical, miss_count=1; TTL=1 hit -> dst 0x20, ttl_exp_count=1.
REQ-038 CPU packet dst 0x01 -> no lkup_req, output bit-identical; 1-beat packet (TLAST first beat) -> back to IDLE after HEAD.
REQ-039 M_AXIS_TREADY toggled every cycle in BODY -> no beat lost/duplicated; reset asserted in BODY -> outputs per REQ-033, next packet processed correctly.
